// File: rtl/button_bank.sv
// Bank of N active-low push buttons: two-flop sync, debounce, press/release pulses.
// Optional auto-repeat pulses while held are built when BUTTON_REPEAT_EN is defined.
module button_bank #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_key,
  output logic [N-1:0] o_pressed,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_repeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (N < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badConfig
    $error("button_bank: all parameters must be at least 1");
  end

  logic [N-1:0]         r_sync1;
  logic [N-1:0]         r_sync2;
  logic [N-1:0][CW-1:0] r_cnt;
  logic [N-1:0]         w_raw;
  logic [N-1:0]         w_accept;

  assign w_raw = ~r_sync2;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N; i++) begin
      w_accept[i] = (w_raw[i] != o_pressed[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      o_pressed <= '0;
      o_press   <= '0;
      o_release <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        o_press[i]   <= w_accept[i] & w_raw[i];
        o_release[i] <= w_accept[i] & ~w_raw[i];
        if (w_accept[i]) begin
          o_pressed[i] <= w_raw[i];
        end
        // Any cycle where raw matches the held level restarts the count.
        if ((w_raw[i] == o_pressed[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [N-1:0][RW-1:0] r_rc;
  logic [N-1:0]         r_periodic;

  // First interval uses the long delay, later ones the shorter period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rc       <= '0;
      r_periodic <= '0;
      o_repeat   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        o_repeat[i] <= 1'b0;
        if (!o_pressed[i] || w_accept[i]) begin
          r_rc[i]       <= '0;
          r_periodic[i] <= 1'b0;
        end else if (r_rc[i] == (r_periodic[i] ? PERIOD_LAST : DELAY_LAST)) begin
          o_repeat[i]   <= 1'b1;
          r_rc[i]       <= '0;
          r_periodic[i] <= 1'b1;
        end else begin
          r_rc[i] <= r_rc[i] + 1'b1;
        end
      end
    end
  end
`else
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: a history-window model checked every cycle,
// plus literal timing expectations for press, release, bounce, repeat and reset.
module tb_button_bank;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key;
  logic [N-1:0] pressed, press, rel, rpt;

  int totalChecks = 0;
  int badChecks   = 0;
  int rptCount0   = 0;

  button_bank #(
    .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_pressed(pressed), .o_press(press), .o_release(rel), .o_repeat(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a new level is accepted once the last DB synchronised samples all
  // differ from the held level; repeats depend only on age since the press.
  logic [N-1:0] hist [0:DB];
  logic [N-1:0] mPressed, mPress, mRelease, mRepeat;
  int           age [N];

  always @(posedge clk or negedge rst_n) begin : model
    bit allDiff;
    int nextAge;
    if (!rst_n) begin
      for (int j = 0; j <= DB; j++) hist[j] <= '1;
      mPressed <= '0;
      mPress   <= '0;
      mRelease <= '0;
      mRepeat  <= '0;
      for (int c = 0; c < N; c++) age[c] <= 0;
    end else begin
      for (int j = DB; j >= 1; j--) hist[j] <= hist[j-1];
      hist[0] <= key;
      for (int c = 0; c < N; c++) begin
        allDiff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if ((~hist[1+j][c]) == mPressed[c]) allDiff = 1'b0;
        end
        nextAge = age[c] + 1;
        mPress[c]   <= allDiff && !mPressed[c];
        mRelease[c] <= allDiff && mPressed[c];
        if (allDiff) mPressed[c] <= ~mPressed[c];
        if (allDiff || !mPressed[c]) age[c] <= 0;
        else age[c] <= nextAge;
`ifdef BUTTON_REPEAT_EN
        mRepeat[c] <= mPressed[c] && !allDiff && (nextAge >= RD) && (((nextAge - RD) % RP) == 0);
`else
        mRepeat[c] <= 1'b0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model_pressed", pressed, mPressed);
    checkOutput("model_press", press, mPress);
    checkOutput("model_release", rel, mRelease);
    checkOutput("model_repeat", rpt, mRepeat);
    if (rpt[0]) rptCount0++;
  end

  task automatic applyStimulus(input logic [N-1:0] k, input int cycles);
    key = k;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int startRpt;
    int expRpt;
`ifdef BUTTON_REPEAT_EN
    logic [N-1:0] expRptBits = 4'b1111;
    expRpt = 5;
`else
    logic [N-1:0] expRptBits = 4'b0000;
    expRpt = 0;
`endif
    rst_n = 1'b0;
    key   = 4'b0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_pressed", pressed, 4'b0000);
    checkOutput("reset_press", press, 4'b0000);
    checkOutput("reset_release", rel, 4'b0000);
    checkOutput("reset_repeat", rpt, 4'b0000);

    // Held keys out of reset: press appears on the 6th negedge.
    rst_n = 1'b1;
    startRpt = rptCount0;
    applyStimulus(4'b0000, 5);
    checkOutput("held_press_early", press, 4'b0000);
    applyStimulus(4'b0000, 1);
    checkOutput("held_press", press, 4'b1111);
    checkOutput("held_pressed", pressed, 4'b1111);
    applyStimulus(4'b0000, 1);
    checkOutput("held_press_once", press, 4'b0000);

    // Repeat window: first pulse 20 cycles after press, then every 8.
    applyStimulus(4'b0000, 18);
    checkOutput("rpt_before_delay", rpt, 4'b0000);
    applyStimulus(4'b0000, 1);
    checkOutput("rpt_first", rpt, expRptBits);
    applyStimulus(4'b0000, 8);
    checkOutput("rpt_second", rpt, expRptBits);
    applyStimulus(4'b0000, 24);
    applyStimulus(4'b1111, 5);
    checkOutput("all_release_early", rel, 4'b0000);
    applyStimulus(4'b1111, 1);
    checkOutput("all_release", rel, 4'b1111);
    checkOutput("all_release_pressed", pressed, 4'b0000);
    checkOutput("all_release_no_rpt", rpt, 4'b0000);
    applyStimulus(4'b1111, 10);
    totalChecks++;
    if (rptCount0 - startRpt != expRpt) begin
      badChecks++;
      $display("[TB] FAIL rpt_count actual=%0d expected=%0d", rptCount0 - startRpt, expRpt);
    end

    // Bounce on key[0]: 3-cycle glitch must not register.
    applyStimulus(4'b1110, 3);
    applyStimulus(4'b1111, 1);
    checkOutput("bounce_glitch_press", press, 4'b0000);
    applyStimulus(4'b1110, 5);
    checkOutput("bounce_press_early", press, 4'b0000);
    applyStimulus(4'b1110, 1);
    checkOutput("bounce_press", press, 4'b0001);

    // key[1] press then release.
    applyStimulus(4'b1100, 10);
    applyStimulus(4'b1110, 5);
    checkOutput("rel1_early", rel, 4'b0000);
    applyStimulus(4'b1110, 1);
    checkOutput("rel1_pulse", rel, 4'b0010);
    checkOutput("rel1_pressed", pressed, 4'b0001);
    checkOutput("rel1_no_press", press, 4'b0000);

    // key[2] pressed and key[3] released on the same cycle.
    applyStimulus(4'b0110, 10);
    applyStimulus(4'b1010, 6);
    checkOutput("indep_press", press, 4'b0100);
    checkOutput("indep_release", rel, 4'b1000);
    checkOutput("indep_pressed", pressed, 4'b0101);

    // Asynchronous reset mid-hold.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midhold_rst_pressed", pressed, 4'b0000);
    checkOutput("midhold_rst_press", press, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 8);

    // Asynchronous reset in the middle of a debounce count on key[1].
    applyStimulus(4'b1101, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midcount_rst_pressed", pressed, 4'b0000);
    key = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 20);
    checkOutput("post_rst_pressed", pressed, 4'b0000);
    checkOutput("post_rst_press", press, 4'b0000);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
